// File: rtl/bcd_digit_feeder.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle) feeding the
// four-digit seven-segment driver; values above 9999 saturate and flag overflow.
module bcd_digit_feeder #(
    parameter int unsigned W = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_value,
    output logic [3:0]   number_0,
    output logic [3:0]   number_1,
    output logic [3:0]   number_2,
    output logic [3:0]   number_3,
    output logic         out_valid,
    output logic         overflow,
    output logic         busy
);

    localparam int unsigned CW = $clog2(W + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state_q;
    logic [W-1:0]  shift_q;
    logic [15:0]   scratch_q;
    logic [15:0]   scratch_adj;
    logic [CW-1:0] count_q;
    logic          ovf_pending_q;
    logic [3:0]    num0_q, num1_q, num2_q, num3_q;
    logic          out_valid_q;
    logic          overflow_q;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    // All four nibbles are corrected from their pre-add values before the shift.
    assign scratch_adj = {add3(scratch_q[15:12]), add3(scratch_q[11:8]),
                          add3(scratch_q[7:4]),   add3(scratch_q[3:0])};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            shift_q       <= '0;
            scratch_q     <= '0;
            count_q       <= '0;
            ovf_pending_q <= 1'b0;
            num0_q        <= 4'd0;
            num1_q        <= 4'd0;
            num2_q        <= 4'd0;
            num3_q        <= 4'd0;
            out_valid_q   <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        shift_q       <= in_value;
                        scratch_q     <= '0;
                        count_q       <= CW'(W);
                        ovf_pending_q <= (32'(in_value) > 32'd9999);
                        state_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_q <= {scratch_adj[14:0], shift_q[W-1]};
                    shift_q   <= {shift_q[W-2:0], 1'b0};
                    count_q   <= count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    num0_q      <= ovf_pending_q ? 4'd9 : scratch_q[3:0];
                    num1_q      <= ovf_pending_q ? 4'd9 : scratch_q[7:4];
                    num2_q      <= ovf_pending_q ? 4'd9 : scratch_q[11:8];
                    num3_q      <= ovf_pending_q ? 4'd9 : scratch_q[15:12];
                    overflow_q  <= ovf_pending_q;
                    out_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && rst;
    assign busy      = (state_q != IDLE);
    assign number_0  = num0_q;
    assign number_1  = num1_q;
    assign number_2  = num2_q;
    assign number_3  = num3_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Directed bench for bcd_digit_feeder: reset, boundaries, held input, abort and a
// reference-model sweep, all checked with immediate assertions.
module tb_bcd_digit_feeder;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_value;
    logic [3:0]   number_0, number_1, number_2, number_3;
    logic         out_valid;
    logic         overflow;
    logic         busy;

    int vectors = 0;
    int miscompares = 0;

    bcd_digit_feeder #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .number_0 (number_0),
        .number_1 (number_1),
        .number_2 (number_2),
        .number_3 (number_3),
        .out_valid(out_valid),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ref_digits(input int v);
        int s;
        s = (v > 9999) ? 9999 : v;
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [15:0] digits();
        return {number_3, number_2, number_1, number_0};
    endfunction

    // One full conversion from an idle block, with latency, busy and pulse-width checks.
    task automatic convert(input int v, input string tag);
        int lat;
        int busy_cnt;
        lat = 0;
        busy_cnt = 0;
        check({tag, ".ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_value = W'(v);
        tick();
        in_valid = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) tick();
            if (busy) busy_cnt++;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(W + 1));
        check({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(W + 1));
        check({tag, ".digits"}, 32'(digits()), 32'(ref_digits(v)));
        check({tag, ".overflow"}, 32'(overflow), 32'(v > 9999));
        check({tag, ".ready_at_pulse"}, 32'(in_ready), 32'd1);
        tick();
        check({tag, ".pulse_width"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int p1, p2, pulses;
        logic [15:0] d1, d2;

        // Reset held for three cycles, with in_valid asserted to show reset wins.
        rst = 1'b0;
        in_valid = 1'b1;
        in_value = W'(99);
        tick();
        tick();
        tick();
        check("rst.digits", 32'(digits()), 32'h0);
        check("rst.overflow", 32'(overflow), 32'd0);
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst.release_ready", 32'(in_ready), 32'd1);
        tick();

        convert(1234, "c1234");
        convert(0, "c0");
        convert(9999, "c9999");
        convert(10000, "c10000");
        convert(16383, "c16383");
        convert(5, "c5");

        // Held in_valid: 7 accepted first, then 42 at the first in_ready cycle.
        pulses = 0;
        p1 = 0;
        p2 = 0;
        d1 = '0;
        d2 = '0;
        in_valid = 1'b1;
        in_value = W'(7);
        tick();
        in_value = W'(42);
        for (int k = 1; k <= 45; k++) begin
            tick();
            if (k == 16) in_valid = 1'b0;
            if (out_valid) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = k;
                    d1 = digits();
                end else begin
                    p2 = k;
                    d2 = digits();
                end
            end
        end
        check("held.pulses", 32'(pulses), 32'd2);
        check("held.first_at", 32'(p1), 32'(W + 1));
        check("held.spacing", 32'(p2 - p1), 32'(W + 2));
        check("held.first_digits", 32'(d1), 32'h0007);
        check("held.second_digits", 32'(d2), 32'h0042);

        // Reset asserted at E5 of a 4321 conversion.
        pulses = 0;
        in_valid = 1'b1;
        in_value = W'(4321);
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            if (out_valid) pulses++;
        end
        check("abort.pulses", 32'(pulses), 32'd0);
        check("abort.digits", 32'(digits()), 32'h0);
        check("abort.busy", 32'(busy), 32'd0);
        convert(4321, "c4321");

        for (int i = 0; i < 1000; i++) begin
            convert(int'($urandom_range(16383, 0)), "sweep");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
